// File: rtl/ws_pe_pkg.sv
// Shared types and clamp helpers for the weight-stationary MAC processing element.
package ws_pe_pkg;

  // Widest accumulator the clamp helpers can describe.
  localparam int unsigned SAT_MAX_W = 64;

  // Direction of an accumulate overflow.
  typedef enum logic [1:0] {
    OVF_NONE = 2'd0,
    OVF_POS  = 2'd1,
    OVF_NEG  = 2'd2
  } ovf_kind_e;

  // Largest representable value of a width-bit accumulator, right-aligned in SAT_MAX_W bits.
  function automatic logic [SAT_MAX_W-1:0] sat_max(input int unsigned width,
                                                   input logic        is_signed);
    logic [SAT_MAX_W-1:0] ones;
    logic [SAT_MAX_W-1:0] res;
    ones = '1;
    if (is_signed) begin
      res = ones >> (SAT_MAX_W - width + 1);
    end else begin
      res = ones >> (SAT_MAX_W - width);
    end
    return res;
  endfunction

  // Smallest representable value of a width-bit accumulator as a width-bit pattern.
  function automatic logic [SAT_MAX_W-1:0] sat_min(input int unsigned width,
                                                   input logic        is_signed);
    logic [SAT_MAX_W-1:0] res;
    res = '0;
    if (is_signed) begin
      res = SAT_MAX_W'(1) << (width - 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/ws_sat_add.sv
// Combinational ACC_W adder with overflow classification and optional clamping.
module ws_sat_add
  import ws_pe_pkg::*;
#(
  parameter int unsigned ACC_W  = 16,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  input  logic             signed_i,
  output logic [ACC_W-1:0] sum_c_o,
  output ovf_kind_e        ovf_kind_c_o
);

  logic [ACC_W:0] raw_sum;
  logic           a_msb;
  logic           b_msb;
  logic           r_msb;

  // Full-width sum keeps the carry for the unsigned overflow test.
  always_comb begin
    raw_sum = {1'b0, a_i} + {1'b0, b_i};
    a_msb   = a_i[ACC_W-1];
    b_msb   = b_i[ACC_W-1];
    r_msb   = raw_sum[ACC_W-1];
  end

  // Classify overflow: carry-out when unsigned, sign flip of like-signed operands when signed.
  always_comb begin
    ovf_kind_c_o = OVF_NONE;
    if (signed_i) begin
      if ((a_msb == b_msb) && (r_msb != a_msb)) begin
        ovf_kind_c_o = a_msb ? OVF_NEG : OVF_POS;
      end
    end else if (raw_sum[ACC_W]) begin
      ovf_kind_c_o = OVF_POS;
    end
  end

  // Clamp to the representable range when saturation is enabled, otherwise wrap.
  always_comb begin
    sum_c_o = raw_sum[ACC_W-1:0];
    if (SAT_EN) begin
      if (ovf_kind_c_o == OVF_POS) begin
        sum_c_o = ACC_W'(sat_max(ACC_W, signed_i));
      end else if (ovf_kind_c_o == OVF_NEG) begin
        sum_c_o = ACC_W'(sat_min(ACC_W, signed_i));
      end
    end
  end

endmodule

// File: rtl/ws_mac_pe_dbuf.sv
// Weight-stationary systolic PE with double-buffered weights, sat/wrap accumulate and stats.
module ws_mac_pe_dbuf
  import ws_pe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WT_W   = 8,
  parameter int unsigned ACC_W  = 16,
  parameter bit          SAT_EN = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [WT_W-1:0]   wt_in,
  input  logic              wt_load,
  input  logic              wt_swap,
  input  logic              signed_mode,
  input  logic              clr_stat,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ACC_W-1:0]  acc_out,
  output logic [WT_W-1:0]   wt_out,
  output logic [CNT_W-1:0]  mac_cnt,
  output logic              ovf_flag
);

  localparam int unsigned PROD_W = DATA_W + WT_W;

  // The accumulator must hold a full product without truncation.
  generate
    if (ACC_W < PROD_W) begin : g_acc_w_chk
      $error("ws_mac_pe_dbuf: ACC_W must be >= DATA_W + WT_W");
    end
  endgenerate

  logic [WT_W-1:0]          wt_sh_q,  wt_sh_d;
  logic [WT_W-1:0]          wt_act_q, wt_act_d;
  logic [DATA_W-1:0]        data_q,   data_d;
  logic                     valid_q,  valid_d;
  logic [ACC_W-1:0]         acc_q,    acc_d;
  logic [CNT_W-1:0]         cnt_q,    cnt_d;
  logic                     ovf_q,    ovf_d;

  logic signed [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0]        prod_u;
  logic [ACC_W-1:0]         prod_ext;
  logic [ACC_W-1:0]         sum_c;
  ovf_kind_e                ovf_kind_c;

  // Product against the currently active weight, extended per this cycle's mode.
  always_comb begin
    prod_s   = PROD_W'($signed(data_in)) * PROD_W'($signed(wt_act_q));
    prod_u   = PROD_W'(data_in) * PROD_W'(wt_act_q);
    prod_ext = signed_mode ? ACC_W'(prod_s) : ACC_W'(prod_u);
  end

  ws_sat_add #(
    .ACC_W  (ACC_W),
    .SAT_EN (SAT_EN)
  ) u_sat_add (
    .a_i          (acc_in),
    .b_i          (prod_ext),
    .signed_i     (signed_mode),
    .sum_c_o      (sum_c),
    .ovf_kind_c_o (ovf_kind_c)
  );

  // Next-state: weight double buffer, systolic pass-through and statistics.
  always_comb begin
    wt_sh_d  = wt_sh_q;
    wt_act_d = wt_act_q;
    data_d   = data_in;
    valid_d  = valid_in;
    acc_d    = acc_in;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    // Swap reads the pre-edge shadow, so load and swap together hand over the old value.
    if (wt_load) begin
      wt_sh_d = wt_in;
    end
    if (wt_swap) begin
      wt_act_d = wt_sh_q;
    end

    if (valid_in) begin
      acc_d = sum_c;
    end

    // Clear wins over a concurrent MAC.
    if (clr_stat) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (valid_in) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (ovf_kind_c != OVF_NONE) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wt_sh_q  <= '0;
      wt_act_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wt_sh_q  <= wt_sh_d;
      wt_act_q <= wt_act_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign acc_out   = acc_q;
  assign wt_out    = wt_sh_q;
  assign mac_cnt   = cnt_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_ws_mac_pe_dbuf.sv
// Scoreboard bench for ws_mac_pe_dbuf: one saturating and one wrapping instance share stimulus.
module tb_ws_mac_pe_dbuf;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [15:0] acc_in;
  logic [7:0]  wt_in;
  logic        wt_load;
  logic        wt_swap;
  logic        signed_mode;
  logic        clr_stat;

  logic [7:0]  data_out_s, data_out_w;
  logic        valid_out_s, valid_out_w;
  logic [15:0] acc_out_s, acc_out_w;
  logic [7:0]  wt_out_s, wt_out_w;
  logic [15:0] mac_cnt_s, mac_cnt_w;
  logic        ovf_s, ovf_w;

  always #5 clk = ~clk;

  ws_mac_pe_dbuf #(.DATA_W(8), .WT_W(8), .ACC_W(16), .SAT_EN(1'b1), .CNT_W(16)) u_sat (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .acc_in(acc_in),
    .wt_in(wt_in), .wt_load(wt_load), .wt_swap(wt_swap), .signed_mode(signed_mode),
    .clr_stat(clr_stat), .data_out(data_out_s), .valid_out(valid_out_s), .acc_out(acc_out_s),
    .wt_out(wt_out_s), .mac_cnt(mac_cnt_s), .ovf_flag(ovf_s)
  );

  ws_mac_pe_dbuf #(.DATA_W(8), .WT_W(8), .ACC_W(16), .SAT_EN(1'b0), .CNT_W(16)) u_wrap (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .acc_in(acc_in),
    .wt_in(wt_in), .wt_load(wt_load), .wt_swap(wt_swap), .signed_mode(signed_mode),
    .clr_stat(clr_stat), .data_out(data_out_w), .valid_out(valid_out_w), .acc_out(acc_out_w),
    .wt_out(wt_out_w), .mac_cnt(mac_cnt_w), .ovf_flag(ovf_w)
  );

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic [15:0] acc_sat;
    logic [15:0] acc_wrap;
    logic [7:0]  wt;
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state: shadow/active weight and statistics.
  logic [7:0]  m_sh  = '0;
  logic [7:0]  m_act = '0;
  logic [15:0] m_cnt = '0;
  logic        m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sh  = '0;
    m_act = '0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs and push the expected registered response.
  task automatic step(input logic v, input logic [7:0] d, input logic [15:0] a,
                      input logic ld, input logic [7:0] w, input logic sw,
                      input logic sm, input logic clr);
    exp_t   e;
    longint p, s, lo, hi;
    logic   ov;
    @(posedge clk);
    #1;
    valid_in = v; data_in = d; acc_in = a; wt_load = ld; wt_in = w;
    wt_swap = sw; signed_mode = sm; clr_stat = clr;

    if (sm) begin
      p  = longint'($signed(m_act)) * longint'($signed(d));
      s  = longint'($signed(a)) + p;
      lo = -32768;
      hi = 32767;
    end else begin
      p  = longint'(m_act) * longint'(d);
      s  = longint'(a) + p;
      lo = 0;
      hi = 65535;
    end
    ov = (s < lo) || (s > hi);

    e.data  = d;
    e.valid = v;
    if (v) begin
      e.acc_wrap = 16'(s);
      e.acc_sat  = (s > hi) ? 16'(hi) : (s < lo) ? 16'(lo) : 16'(s);
    end else begin
      e.acc_wrap = a;
      e.acc_sat  = a;
    end

    if (clr) begin
      m_cnt = '0;
      m_ovf = 1'b0;
    end else if (v) begin
      m_cnt = m_cnt + 16'd1;
      if (ov) m_ovf = 1'b1;
    end
    if (sw) m_act = m_sh;
    if (ld) m_sh = w;

    e.wt  = m_sh;
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] w);
    step(1'b0, 8'h00, 16'h0000, 1'b1, w, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic swap();
    step(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic mac(input logic [7:0] d, input logic [15:0] a, input logic sm);
    step(1'b1, d, a, 1'b0, 8'h00, 1'b0, sm, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_out"},  32'(data_out_s),  32'h0);
    check({tag, "_valid_out"}, 32'(valid_out_s), 32'h0);
    check({tag, "_acc_out"},   32'(acc_out_s),   32'h0);
    check({tag, "_wt_out"},    32'(wt_out_s),    32'h0);
    check({tag, "_mac_cnt"},   32'(mac_cnt_s),   32'h0);
    check({tag, "_ovf_flag"},  32'(ovf_s),       32'h0);
    check({tag, "_acc_wrap"},  32'(acc_out_w),   32'h0);
  endtask

  // Load, swap, then one unsigned MAC: 3*5+10 = 25.
  task automatic scenario_first();
    load(8'h05);
    idle();
    @(negedge clk);
    check("load_wt_out", 32'(wt_out_s), 32'h05);
    swap();
    mac(8'd3, 16'd10, 1'b0);
    idle();
    @(negedge clk);
    check("first_acc_out", 32'(acc_out_s), 32'd25);
    check("first_mac_cnt", 32'(mac_cnt_s), 32'd1);
  endtask

  // Monitor: pop one expectation per registered cycle and compare both instances.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        @(negedge clk);
        check("mon_data_out",  32'(data_out_s),  32'(e.data));
        check("mon_valid_out", 32'(valid_out_s), 32'(e.valid));
        check("mon_acc_sat",   32'(acc_out_s),   32'(e.acc_sat));
        check("mon_acc_wrap",  32'(acc_out_w),   32'(e.acc_wrap));
        check("mon_wt_out",    32'(wt_out_s),    32'(e.wt));
        check("mon_mac_cnt",   32'(mac_cnt_s),   32'(e.cnt));
        check("mon_cnt_wrap",  32'(mac_cnt_w),   32'(e.cnt));
        check("mon_ovf_sat",   32'(ovf_s),       32'(e.ovf));
        check("mon_ovf_wrap",  32'(ovf_w),       32'(e.ovf));
      end
    end
  end

  initial begin
    int          guard;
    logic [15:0] a;
    logic [15:0] cnt_before;

    reset = 1'b0;
    valid_in = 1'b0; data_in = '0; acc_in = '0; wt_in = '0;
    wt_load = 1'b0; wt_swap = 1'b0; signed_mode = 1'b0; clr_stat = 1'b0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;

    scenario_first();

    // Simultaneous load and swap: active takes old shadow 5, shadow takes 7.
    load(8'h05);
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
    mac(8'd1, 16'd0, 1'b0);
    idle();
    @(negedge clk);
    check("ldsw_wt_out", 32'(wt_out_s), 32'h07);
    check("ldsw_acc_out", 32'(acc_out_s), 32'd5);

    // Signed positive overflow: -2 * -128 + 0x7FF0.
    load(8'hFE);
    swap();
    mac(8'h80, 16'h7FF0, 1'b1);
    idle();
    @(negedge clk);
    check("ssat_acc_sat", 32'(acc_out_s), 32'h7FFF);
    check("ssat_acc_wrap", 32'(acc_out_w), 32'h80F0);
    check("ssat_ovf", 32'(ovf_s), 32'h1);

    // Unsigned overflow after a stats clear: 255*255 + 0x1000.
    step(1'b0, 8'h00, 16'h0000, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    swap();
    mac(8'hFF, 16'h1000, 1'b0);
    idle();
    @(negedge clk);
    check("usat_acc_sat", 32'(acc_out_s), 32'hFFFF);
    check("usat_acc_wrap", 32'(acc_out_w), 32'h0E01);
    check("usat_ovf_sat", 32'(ovf_s), 32'h1);
    check("usat_ovf_wrap", 32'(ovf_w), 32'h1);

    // Bubble passes acc_in through, then clear beats a concurrent valid MAC.
    cnt_before = mac_cnt_s;
    step(1'b0, 8'h11, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("bubble_acc_out", 32'(acc_out_s), 32'h1234);
    check("bubble_mac_cnt", 32'(mac_cnt_s), 32'(cnt_before));
    step(1'b1, 8'h02, 16'h0005, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    idle();
    @(negedge clk);
    check("clr_mac_cnt", 32'(mac_cnt_s), 32'h0);
    check("clr_ovf", 32'(ovf_s), 32'h0);

    // Randomized traffic with operands biased toward the accumulator edges.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       a = {($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80, 8'($urandom)};
        1:       a = {($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 8'($urandom)};
        default: a = 16'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), 8'($urandom), a,
           ($urandom_range(0, 4) == 0), 8'($urandom), ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end

    // Reset dropped mid-stream, between edges, while valid MACs keep arriving.
    for (int i = 0; i < 5; i++) begin
      mac(8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    valid_in = 1'b0; data_in = '0; acc_in = '0; wt_in = '0;
    wt_load = 1'b0; wt_swap = 1'b0; signed_mode = 1'b0; clr_stat = 1'b0;
    #1;
    reset = 1'b1;

    scenario_first();

    guard = 0;
    while (q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(q.size()), 32'h0);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
